// File: rtl/led_blink_pkg.sv
// Mode codes, per-channel state encoding and state decode helpers
// shared by the multi-channel LED blinker.
package led_blink_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SOLID  = 3'd1,
        ST_BLK_LO = 3'd2,
        ST_BLK_HI = 3'd3,
        ST_BST_LO = 3'd4,
        ST_BST_HI = 3'd5,
        ST_DONE   = 3'd6
    } ch_state_e;

    function automatic logic state_led(input ch_state_e s);
        return (s == ST_SOLID) || (s == ST_BLK_HI) || (s == ST_BST_HI);
    endfunction

    // States whose level length is measured in ticks by the phase counter.
    function automatic logic state_phased(input ch_state_e s);
        return (s == ST_BLK_LO) || (s == ST_BLK_HI) ||
               (s == ST_BST_LO) || (s == ST_BST_HI);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clk cycles,
// high while the counter sits at TICK_DIV-1.
module led_tick_gen #(
    parameter int TICK_DIV = 25000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + DIV_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/multi_led_blinker.sv
// NUM_CH independent LED channels (off / on / blink / counted burst) paced
// by one shared tick and configured at run time through a write port.
module multi_led_blinker
    import led_blink_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  CNT_W    = 16,
    parameter int  TICK_DIV = 25000,
    parameter int  BURST_W  = 4,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_mode,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [BURST_W-1:0] cfg_burst,
    output logic [NUM_CH-1:0]  led,
    output logic [NUM_CH-1:0]  ch_done,
    output logic               tick
);

    logic [CNT_W-1:0] period_fix;
    assign period_fix = (cfg_period == '0) ? CNT_W'(1) : cfg_period;

    led_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_e          state_q, state_d;
        logic [CNT_W-1:0]   phase_q, phase_d;
        logic [CNT_W-1:0]   period_q, period_d;
        logic [BURST_W-1:0] remain_q, remain_d;
        logic               led_q, led_d;
        logic               done_q, done_d;
        logic               wr_hit;

        // Out-of-range indices match no channel and are therefore ignored.
        assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));

        // NOTE: every _d gets a default before any branch so no path leaves
        // it unassigned, which would otherwise infer a latch.
        always_comb begin
            state_d  = state_q;
            phase_d  = phase_q;
            period_d = period_q;
            remain_d = remain_q;
            done_d   = 1'b0;

            if (wr_hit) begin
                phase_d  = '0;
                period_d = period_fix;
                remain_d = cfg_burst;
                case (cfg_mode)
                    MODE_OFF:   state_d = ST_IDLE;
                    MODE_ON:    state_d = ST_SOLID;
                    MODE_BLINK: state_d = ST_BLK_LO;
                    default: begin
                        if (cfg_burst == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_BST_LO;
                        end
                    end
                endcase
            end else if (tick && state_phased(state_q)) begin
                if (phase_q == period_q - CNT_W'(1)) begin
                    phase_d = '0;
                    case (state_q)
                        ST_BLK_LO: state_d = ST_BLK_HI;
                        ST_BLK_HI: state_d = ST_BLK_LO;
                        ST_BST_LO: state_d = ST_BST_HI;
                        ST_BST_HI: begin
                            remain_d = remain_q - BURST_W'(1);
                            if (remain_q == BURST_W'(1)) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_BST_LO;
                            end
                        end
                        default: state_d = state_q;
                    endcase
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end

            led_d = state_led(state_d);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q  <= ST_IDLE;
                phase_q  <= '0;
                period_q <= CNT_W'(1);
                remain_q <= '0;
                led_q    <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                phase_q  <= phase_d;
                period_q <= period_d;
                remain_q <= remain_d;
                led_q    <= led_d;
                done_q   <= done_d;
            end
        end

        assign led[i]     = led_q;
        assign ch_done[i] = done_q;
    end

endmodule

// File: tb/tb_multi_led_blinker.sv
// Scoreboard bench: a closed-form reference model predicts led/ch_done/tick
// after every edge; a negedge monitor pops and compares against the DUT.
module tb_multi_led_blinker;

    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 8;
    localparam int TICK_DIV = 4;
    localparam int BURST_W  = 4;
    localparam int CH_W     = 2;
    localparam int NUM_CH2  = 6;
    localparam int CH_W2    = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_we;
    logic [CH_W-1:0]      cfg_ch;
    logic [1:0]           cfg_mode;
    logic [CNT_W-1:0]     cfg_period;
    logic [BURST_W-1:0]   cfg_burst;
    logic [NUM_CH-1:0]    led;
    logic [NUM_CH-1:0]    ch_done;
    logic                 tick;

    logic                 cfg2_we;
    logic [CH_W2-1:0]     cfg2_ch;
    logic [1:0]           cfg2_mode;
    logic [CNT_W-1:0]     cfg2_period;
    logic [BURST_W-1:0]   cfg2_burst;
    logic [NUM_CH2-1:0]   led2;
    logic [NUM_CH2-1:0]   ch_done2;
    logic                 tick2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_led_blinker #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV), .BURST_W(BURST_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_burst(cfg_burst),
        .led(led), .ch_done(ch_done), .tick(tick)
    );

    multi_led_blinker #(
        .NUM_CH(NUM_CH2), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV), .BURST_W(BURST_W)
    ) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg2_we), .cfg_ch(cfg2_ch),
        .cfg_mode(cfg2_mode), .cfg_period(cfg2_period), .cfg_burst(cfg2_burst),
        .led(led2), .ch_done(ch_done2), .tick(tick2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int mode;
        int period;
        int burst;
        int wcyc;
    } mcfg_t;

    typedef struct packed {
        logic [NUM_CH-1:0] led;
        logic [NUM_CH-1:0] done;
        logic              tk;
    } exp_t;

    mcfg_t mcfg [NUM_CH];
    exp_t  exp_q [$];
    exp_t  mon_e;
    exp_t  tmp_e;
    int    cyc = 0;

    // Completed half-periods of channel i at edge c; edge e carries a tick
    // when e is a multiple of TICK_DIV, and the write edge's own tick is lost.
    function automatic int level(input int i, input int c);
        return (c / TICK_DIV - mcfg[i].wcyc / TICK_DIV) / mcfg[i].period;
    endfunction

    function automatic exp_t predict(input int c);
        exp_t e;
        e    = '0;
        e.tk = ((c % TICK_DIV) == TICK_DIV - 1);
        for (int i = 0; i < NUM_CH; i++) begin
            case (mcfg[i].mode)
                1: e.led[i] = 1'b1;
                2: e.led[i] = (level(i, c) % 2) == 1;
                3: begin
                    if (mcfg[i].burst == 0) begin
                        e.done[i] = (c == mcfg[i].wcyc);
                    end else begin
                        int l;
                        int n;
                        l = level(i, c);
                        n = 2 * mcfg[i].burst;
                        e.led[i]  = (l < n) && ((l % 2) == 1);
                        e.done[i] = (c > mcfg[i].wcyc) && (l == n) && (level(i, c - 1) < n);
                    end
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc = 0;
            for (int i = 0; i < NUM_CH; i++) mcfg[i] = '{0, 1, 0, 0};
            exp_q.delete();
        end else begin
            cyc++;
            if (cfg_we && int'(cfg_ch) < NUM_CH) begin
                mcfg[int'(cfg_ch)] = '{int'(cfg_mode),
                                       (cfg_period == '0) ? 1 : int'(cfg_period),
                                       int'(cfg_burst), cyc};
            end
            exp_q.push_back(predict(cyc));
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst === 1'b1 && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("led", 32'(led), 32'(mon_e.led));
            check("ch_done", 32'(ch_done), 32'(mon_e.done));
            check("tick", 32'(tick), 32'(mon_e.tk));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_cfg(input int ch, input int mode, input int per, input int bst);
        cfg_we     = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_mode   = 2'(mode);
        cfg_period = CNT_W'(per);
        cfg_burst  = BURST_W'(bst);
        @(negedge clk);
        cfg_we     = 1'b0;
    endtask

    task automatic write2(input int ch, input int mode, input int per);
        cfg2_we     = 1'b1;
        cfg2_ch     = CH_W2'(ch);
        cfg2_mode   = 2'(mode);
        cfg2_period = CNT_W'(per);
        cfg2_burst  = '0;
        @(negedge clk);
        cfg2_we     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_period = '0; cfg_burst = '0;
        cfg2_we = 1'b0; cfg2_ch = '0; cfg2_mode = '0; cfg2_period = '0; cfg2_burst = '0;

        #45;
        check("rst_led", 32'(led), 32'd0);
        check("rst_ch_done", 32'(ch_done), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_led2", 32'(led2), 32'd0);
        #7 rst = 1'b1;

        // Quiet run: only the tick cadence moves.
        idle(200);

        // Solid on, then off.
        write_cfg(0, 1, 0, 0);
        idle(5);
        write_cfg(0, 0, 0, 0);
        idle(5);

        // Blink with period 3, then period 0 (treated as 1).
        write_cfg(1, 2, 3, 0);
        idle(60);
        write_cfg(1, 2, 0, 0);
        idle(30);
        write_cfg(1, 0, 0, 0);

        // Burst of 3 with period 2, then an empty burst.
        write_cfg(2, 3, 2, 3);
        idle(65);
        write_cfg(2, 3, 1, 0);
        idle(10);

        // Randomized configuration traffic.
        for (int k = 0; k < 40; k++) begin
            write_cfg($urandom_range(NUM_CH - 1, 0), $urandom_range(3, 0),
                      $urandom_range(3, 0), $urandom_range(3, 0));
            idle($urandom_range(40, 1));
        end

        // Write landing on the edge where ch3 would toggle low->high.
        write_cfg(3, 2, 1, 0);
        idle(6);
        for (int k = 0; k < 16; k++) begin
            tmp_e = predict(cyc + 1);
            if (((cyc + 1) % TICK_DIV == 0) && tmp_e.led[3]) break;
            @(negedge clk);
        end
        write_cfg(3, 2, 2, 0);
        idle(30);

        // Asynchronous reset mid-pattern.
        write_cfg(1, 2, 1, 0);
        write_cfg(3, 3, 1, 5);
        idle(13);
        #2 rst = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'd0);
        check("async_rst_ch_done", 32'(ch_done), 32'd0);
        check("async_rst_tick", 32'(tick), 32'd0);
        #20 rst = 1'b1;
        idle(40);

        // Out-of-range indices on a 6-channel instance with a 3-bit index.
        write2(6, 1, 0);
        write2(7, 2, 1);
        idle(10);
        check("oor_led2", 32'(led2), 32'd0);
        check("oor_ch_done2", 32'(ch_done2), 32'd0);
        write2(5, 1, 0);
        check("ch5_led2", 32'(led2), 32'h20);

        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
